// File: rtl/buffer_read_scheduler_pkg.sv
// Shared encodings and helpers for the buffer read scheduler.
// Only PU_ID_W sizing and the buffered-read type test depend on this package.
package buffer_read_scheduler_pkg;

   localparam int D_TYPE_RAW  = 0;
   localparam int D_TYPE_BUF  = 1;
   localparam int D_TYPE_WGT  = 2;
   localparam int D_TYPE_BIAS = 3;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int c_log_2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/buffer_read_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// ptr is assumed to be below NUM_PU.
module buffer_read_scheduler_rr_arbiter #(
   parameter int NUM_PU = 4,
   parameter int IDX_W  = 3
) (
   input  logic [NUM_PU-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_PU-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              valid
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      for (int k = 0; k < NUM_PU; k++) begin
         if (!valid && req[(int'(ptr) + k) % NUM_PU]) begin
            valid                              = 1'b1;
            grant[(int'(ptr) + k) % NUM_PU]    = 1'b1;
            grant_idx                          = IDX_W'((int'(ptr) + k) % NUM_PU);
         end
      end
   end

endmodule

// File: rtl/buffer_read_scheduler.sv
// Shares the memory-controller read port between NUM_PU requesters, round-robin,
// with credit and FIFO-space gating applied only to buffered (d_type 1) reads.
//
// state | meaning
// IDLE  | arbitrate among eligible requesters, latch the winner's read
// ISSUE | present latched read on rd_req until rd_ready, then grant the winner
module buffer_read_scheduler
   import buffer_read_scheduler_pkg::*;
#(
   parameter int NUM_PU          = 4,
   parameter int RD_SIZE_W       = 20,
   parameter int D_TYPE_W        = 2,
   parameter int PU_ID_W         = c_log_2(NUM_PU) + 1,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PU-1:0]             pu_req,
   input  logic [NUM_PU*RD_SIZE_W-1:0]   pu_req_size,
   input  logic [NUM_PU*D_TYPE_W-1:0]    pu_req_d_type,
   output logic [NUM_PU-1:0]             pu_grant,
   output logic                          rd_req,
   input  logic                          rd_ready,
   output logic [RD_SIZE_W-1:0]          rd_req_size,
   output logic [PU_ID_W-1:0]            rd_req_pu_id,
   output logic [D_TYPE_W-1:0]           rd_req_d_type,
   input  logic                          read_info_full,
   input  logic                          rd_done,
   output logic [7:0]                    outstanding,
   output logic                          underflow_err
);

   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [7:0]          MAX_OUT_C = 8'(MAX_OUTSTANDING);
   localparam logic [D_TYPE_W-1:0] BUF_C     = D_TYPE_W'(D_TYPE_BUF);
   localparam logic [PU_ID_W-1:0]  LAST_PU   = PU_ID_W'(NUM_PU - 1);

   state_t                state_q, state_d;
   logic [PU_ID_W-1:0]    rr_ptr_q;
   logic [NUM_PU-1:0]     eligible, win_grant;
   logic [PU_ID_W-1:0]    win_idx;
   logic                  win_valid;
   logic [RD_SIZE_W-1:0]  win_size;
   logic [D_TYPE_W-1:0]   win_d_type;
   logic                  credit_ok, load, accept, inc;

   always_comb begin
      credit_ok = !read_info_full && (outstanding < MAX_OUT_C);
      eligible  = '0;
      for (int i = 0; i < NUM_PU; i++) begin
         eligible[i] = pu_req[i] &&
                       (pu_req_d_type[i*D_TYPE_W +: D_TYPE_W] != BUF_C || credit_ok);
      end
   end

   buffer_read_scheduler_rr_arbiter #(
      .NUM_PU (NUM_PU),
      .IDX_W  (PU_ID_W)
   ) u_rr_arbiter (
      .req       (eligible),
      .ptr       (rr_ptr_q),
      .grant     (win_grant),
      .grant_idx (win_idx),
      .valid     (win_valid)
   );

   always_comb begin
      win_size   = '0;
      win_d_type = '0;
      for (int i = 0; i < NUM_PU; i++) begin
         if (win_grant[i]) begin
            win_size   = pu_req_size[i*RD_SIZE_W +: RD_SIZE_W];
            win_d_type = pu_req_d_type[i*D_TYPE_W +: D_TYPE_W];
         end
      end
   end

   // A reset landing while ISSUE is waiting on rd_ready must not leak a grant.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      accept   = 1'b0;
      pu_grant = '0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (rd_ready && !reset) begin
               accept   = 1'b1;
               pu_grant = NUM_PU'(1) << rd_req_pu_id;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      inc = accept && (rd_req_d_type == BUF_C);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         rd_req        <= 1'b0;
         rd_req_size   <= '0;
         rd_req_pu_id  <= '0;
         rd_req_d_type <= '0;
         outstanding   <= '0;
         underflow_err <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_req  <= (state_d == ISSUE);
         if (load) begin
            rd_req_size   <= win_size;
            rd_req_pu_id  <= win_idx;
            rd_req_d_type <= win_d_type;
         end
         if (accept) begin
            rr_ptr_q <= (rd_req_pu_id == LAST_PU) ? '0 : rd_req_pu_id + PU_ID_W'(1);
         end
         // Accept and completion in the same cycle cancel out.
         if (inc && !rd_done) begin
            outstanding <= outstanding + 8'd1;
         end else if (rd_done && !inc) begin
            if (outstanding == 8'd0) underflow_err <= 1'b1;
            else                     outstanding   <= outstanding - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_buffer_read_scheduler.sv
// Directed bench for buffer_read_scheduler: per-cycle vector table plus a
// hand-written credit-exhaustion sequence with MAX_OUTSTANDING = 2.
module tb_buffer_read_scheduler;

   localparam logic [19:0] S0 = 20'd16;
   localparam logic [19:0] S1 = 20'h00100;
   localparam logic [19:0] S2 = 20'h02222;
   localparam logic [19:0] S3 = 20'hFFFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pu_req;
   logic [79:0] pu_req_size;
   logic [7:0]  pu_req_d_type;
   logic [3:0]  pu_grant;
   logic        rd_req;
   logic        rd_ready;
   logic [19:0] rd_req_size;
   logic [2:0]  rd_req_pu_id;
   logic [1:0]  rd_req_d_type;
   logic        read_info_full;
   logic        rd_done;
   logic [7:0]  outstanding;
   logic        underflow_err;

   int errors = 0;
   int checks = 0;

   buffer_read_scheduler #(
      .NUM_PU(4), .RD_SIZE_W(20), .D_TYPE_W(2), .PU_ID_W(3), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .reset(reset), .pu_req(pu_req), .pu_req_size(pu_req_size),
      .pu_req_d_type(pu_req_d_type), .pu_grant(pu_grant), .rd_req(rd_req),
      .rd_ready(rd_ready), .rd_req_size(rd_req_size), .rd_req_pu_id(rd_req_pu_id),
      .rd_req_d_type(rd_req_d_type), .read_info_full(read_info_full),
      .rd_done(rd_done), .outstanding(outstanding), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [7:0]  dt;
      logic        full;
      logic        rdy;
      logic        done;
      logic        e_req;
      logic [3:0]  e_grant;
      logic [2:0]  e_id;
      logic [19:0] e_size;
      logic [1:0]  e_dt;
      logic [7:0]  e_out;
      logic        e_uf;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic [3:0] req, input logic [7:0] dt,
                      input logic full, input logic rdy, input logic done,
                      input logic e_req, input logic [3:0] e_grant, input logic [2:0] e_id,
                      input logic [19:0] e_size, input logic [1:0] e_dt,
                      input logic [7:0] e_out, input logic e_uf);
      vec_t v;
      v.rst = rst; v.req = req; v.dt = dt; v.full = full; v.rdy = rdy; v.done = done;
      v.e_req = e_req; v.e_grant = e_grant; v.e_id = e_id; v.e_size = e_size;
      v.e_dt = e_dt; v.e_out = e_out; v.e_uf = e_uf;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int row, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (row %0d): got %0h expected %0h", nm, row, got, exp);
      end
   endtask

   logic [3:0] req_v;
   logic [3:0] gr [3];
   int         ngr;
   int         extra_req, extra_grant;

   initial begin
      reset = 1'b1; pu_req = '0; pu_req_d_type = '0; rd_ready = 1'b0;
      read_info_full = 1'b0; rd_done = 1'b0;
      pu_req_size = {S3, S2, S1, S0};

      //  rst req     dt     full rdy done | rdreq grant   id  size dt out uf
      add(0, 4'b0000, 8'h00, 0, 0, 0,   0, 4'b0000, 0, 0,  0, 0, 0); // r0 reset values
      add(0, 4'b0001, 8'h01, 0, 1, 0,   0, 4'b0000, 0, 0,  0, 0, 0); // r1 PU0 buf req
      add(0, 4'b0001, 8'h01, 0, 1, 0,   1, 4'b0001, 0, S0, 1, 0, 0); // r2 issue+grant
      add(0, 4'b0000, 8'h01, 0, 1, 0,   0, 4'b0000, 0, S0, 1, 1, 0);
      add(0, 4'b0000, 8'h01, 0, 1, 1,   0, 4'b0000, 0, S0, 1, 1, 0);
      add(0, 4'b0000, 8'h01, 0, 1, 0,   0, 4'b0000, 0, S0, 1, 0, 0);
      add(1, 4'b0000, 8'h00, 0, 1, 0,   0, 4'b0000, 0, S0, 1, 0, 0); // r6 reset
      add(0, 4'b1111, 8'h00, 0, 1, 0,   0, 4'b0000, 0, 0,  0, 0, 0); // r7 round robin
      add(0, 4'b1111, 8'h00, 0, 1, 0,   1, 4'b0001, 0, S0, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   0, 4'b0000, 0, S0, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   1, 4'b0010, 1, S1, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   0, 4'b0000, 1, S1, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   1, 4'b0100, 2, S2, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   0, 4'b0000, 2, S2, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   1, 4'b1000, 3, S3, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   0, 4'b0000, 3, S3, 0, 0, 0);
      add(0, 4'b1111, 8'h00, 0, 1, 0,   1, 4'b0001, 0, S0, 0, 0, 0); // r16 wraps to 0
      add(0, 4'b0110, 8'h04, 1, 1, 0,   0, 4'b0000, 0, S0, 0, 0, 0); // r17 full: PU1 blocked
      add(0, 4'b0110, 8'h04, 1, 1, 0,   1, 4'b0100, 2, S2, 0, 0, 0);
      add(0, 4'b0010, 8'h04, 1, 1, 0,   0, 4'b0000, 2, S2, 0, 0, 0);
      add(0, 4'b0010, 8'h04, 1, 1, 0,   0, 4'b0000, 2, S2, 0, 0, 0);
      add(0, 4'b0010, 8'h04, 0, 1, 0,   0, 4'b0000, 2, S2, 0, 0, 0); // r21 full drops
      add(0, 4'b0010, 8'h04, 0, 1, 0,   1, 4'b0010, 1, S1, 1, 0, 0);
      add(0, 4'b0000, 8'h04, 0, 1, 0,   0, 4'b0000, 1, S1, 1, 1, 0);
      add(0, 4'b0001, 8'h01, 0, 0, 0,   0, 4'b0000, 1, S1, 1, 1, 0); // r24 stall test
      for (int i = 0; i < 5; i++)
         add(0, 4'b0001, 8'h01, 0, 0, 0, 1, 4'b0000, 0, S0, 1, 1, 0);
      add(0, 4'b0001, 8'h01, 0, 1, 1,   1, 4'b0001, 0, S0, 1, 1, 0); // r30 accept+done
      add(0, 4'b0000, 8'h01, 0, 1, 0,   0, 4'b0000, 0, S0, 1, 1, 0);
      add(0, 4'b0000, 8'h01, 0, 1, 1,   0, 4'b0000, 0, S0, 1, 1, 0);
      add(0, 4'b0000, 8'h01, 0, 1, 1,   0, 4'b0000, 0, S0, 1, 0, 0); // r33 underflow
      add(0, 4'b0000, 8'h01, 0, 1, 0,   0, 4'b0000, 0, S0, 1, 0, 1);
      add(0, 4'b1000, 8'h00, 0, 0, 0,   0, 4'b0000, 0, S0, 1, 0, 1); // r35 PU3 raw
      add(0, 4'b1000, 8'h00, 0, 0, 0,   1, 4'b0000, 3, S3, 0, 0, 1);
      add(1, 4'b1000, 8'h00, 0, 1, 0,   1, 4'b0000, 3, S3, 0, 0, 1); // r37 reset mid-ISSUE
      add(0, 4'b0000, 8'h00, 0, 0, 0,   0, 4'b0000, 0, 0,  0, 0, 0);

      repeat (2) @(posedge clk);
      foreach (vq[r]) begin
         @(posedge clk); #1;
         reset = vq[r].rst; pu_req = vq[r].req; pu_req_d_type = vq[r].dt;
         read_info_full = vq[r].full; rd_ready = vq[r].rdy; rd_done = vq[r].done;
         @(negedge clk);
         chk("rd_req",        r, 32'(rd_req),        32'(vq[r].e_req));
         chk("pu_grant",      r, 32'(pu_grant),      32'(vq[r].e_grant));
         chk("rd_req_pu_id",  r, 32'(rd_req_pu_id),  32'(vq[r].e_id));
         chk("rd_req_size",   r, 32'(rd_req_size),   32'(vq[r].e_size));
         chk("rd_req_d_type", r, 32'(rd_req_d_type), 32'(vq[r].e_dt));
         chk("outstanding",   r, 32'(outstanding),   32'(vq[r].e_out));
         chk("underflow_err", r, 32'(underflow_err), 32'(vq[r].e_uf));
      end

      // Credit exhaustion: three buffered reads against two credits.
      @(posedge clk); #1;
      reset = 1'b1; pu_req = '0; rd_ready = 1'b0; rd_done = 1'b0; read_info_full = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; pu_req_d_type = 8'h15; rd_ready = 1'b1;
      req_v = 4'b0111; ngr = 0;
      gr[0] = '0; gr[1] = '0; gr[2] = '0;
      for (int c = 0; c < 20 && ngr < 2; c++) begin
         pu_req = req_v;
         @(negedge clk);
         if (pu_grant != 4'b0000) begin
            gr[ngr] = pu_grant;
            ngr++;
            req_v = req_v & ~pu_grant;
         end
         @(posedge clk); #1;
      end
      chk("cred grants seen", 100, 32'(ngr), 32'd2);
      chk("cred first grant", 100, 32'(gr[0]), 32'h1);
      chk("cred second grant", 100, 32'(gr[1]), 32'h2);
      extra_req = 0; extra_grant = 0;
      for (int c = 0; c < 6; c++) begin
         pu_req = req_v;
         @(negedge clk);
         if (rd_req) extra_req++;
         if (pu_grant != 4'b0000) extra_grant++;
         @(posedge clk); #1;
      end
      chk("cred third held rd_req", 101, 32'(extra_req), 32'd0);
      chk("cred third held grant", 101, 32'(extra_grant), 32'd0);
      chk("cred outstanding full", 101, 32'(outstanding), 32'd2);
      rd_done = 1'b1;
      @(posedge clk); #1;
      rd_done = 1'b0;
      @(negedge clk);
      chk("cred after done", 102, 32'(outstanding), 32'd1);
      ngr = 0;
      for (int c = 0; c < 10 && ngr == 0; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (pu_grant != 4'b0000) begin
            gr[2] = pu_grant;
            ngr = 1;
            chk("cred third pu_id", 103, 32'(rd_req_pu_id), 32'd2);
         end
      end
      chk("cred third grant", 103, 32'(gr[2]), 32'h4);
      @(posedge clk); #1;
      pu_req = '0;
      @(negedge clk);
      chk("cred outstanding back", 104, 32'(outstanding), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/buffer_read_scheduler.md
# buffer_read_scheduler

Round-robin scheduler that shares the memory-controller read-request port between NUM_PU processing-unit requesters. Each cycle it selects one eligible requester, presents its read to the memory controller with a stable request/ready handshake, and pulses a grant back to the winner. Buffered reads (d_type 1) are admitted only while the downstream read-info FIFO has room and an outstanding-read credit is free; completions are returned by the buffer-read side.

## Interface
- NUM_PU, 4, number of requesting PUs (≥1)
- RD_SIZE_W, 20, read size width
- D_TYPE_W, 2, data-type field width
- PU_ID_W, C_LOG_2(NUM_PU)+1, PU id width
- MAX_OUTSTANDING, 8, max accepted-but-incomplete d_type 1 reads (≤ 2^8-1)
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- pu_req  in  NUM_PU  per-PU request level; held until granted
- pu_req_size  in  NUM_PU*RD_SIZE_W  packed sizes, PU i at [i*RD_SIZE_W +: RD_SIZE_W]
- pu_req_d_type  in  NUM_PU*D_TYPE_W  packed data types, same packing
- pu_grant  out  NUM_PU  one-hot, one-cycle pulse on acceptance
- rd_req  out  1  read request valid to memory controller
- rd_ready  in  1  memory controller accepts when rd_req && rd_ready
- rd_req_size  out  RD_SIZE_W  size of presented read
- rd_req_pu_id  out  PU_ID_W  index of winning PU
- rd_req_d_type  out  D_TYPE_W  data type of presented read
- read_info_full  in  1  registered full flag of downstream read-info FIFO
- rd_done  in  1  one-cycle pulse: one d_type 1 read fully drained
- outstanding  out  8  current d_type 1 credit usage
- underflow_err  out  1  sticky: rd_done seen with outstanding == 0

## Operation
- States: IDLE, ISSUE.
- Eligibility of PU i: pu_req[i] && (d_type_i != 1 || (!read_info_full && outstanding < MAX_OUTSTANDING)).
- IDLE: if any eligible, pick first eligible index scanning from rr_ptr upward, wrapping mod NUM_PU; register size, d_type, id; go ISSUE. Otherwise stay.
- ISSUE: rd_req = 1, fields held stable. On rd_req && rd_ready: pu_grant[winner] = 1 same cycle; rr_ptr ← (winner+1) mod NUM_PU; if d_type == 1, outstanding +1; return to IDLE.
- Once in ISSUE the request is never withdrawn, even if read_info_full rises (credit was checked at selection).
- rd_done: outstanding −1; simultaneous accept(d_type 1) and rd_done → unchanged; rd_done at 0 → stays 0, underflow_err set until reset.
- Non-1 d_types bypass credit/full gating and never touch outstanding.
- Sizes/types passed through unmodified; no width conversion.

## Timing
- Reset values: rd_req 0, pu_grant 0, rd_req_size/pu_id/d_type 0, outstanding 0, underflow_err 0, rr_ptr 0, state IDLE.
- Latency: pu_req sampled eligible in cycle t → rd_req high in t+1; earliest grant t+1 when rd_ready high.
- Back-to-back throughput: one accept per 2 cycles (IDLE re-arbitrates after each accept).
- All outputs registered except pu_grant (combinational from state, rd_ready).
- Requester may drop pu_req only after its grant pulse; dropping earlier is illegal (undefined).
- Reset mid-ISSUE: request abandoned, no grant, all state cleared next cycle.

## Structure
- Shared package/header: D_TYPE encodings (D_TYPE_BUF = 1 etc.) and C_LOG_2 macro; no new typedefs.
- One sub-module natural: rr_arbiter (NUM_PU-wide request vector + pointer → one-hot winner, valid), purely combinational.
- Credit counter inline (8-bit up/down with saturation at 0).

## Test plan
- Single PU0 req size 16, d_type 1, rd_ready=1 → rd_req 1 cycle after req, pu_grant=0001 same cycle, rd_req_pu_id 0, outstanding 1.
- PU0..3 all requesting d_type 0, rd_ready=1 → grants in order 0,1,2,3,0, one every 2 cycles.
- MAX_OUTSTANDING=2, three d_type 1 reads, no rd_done → two accepted, third held off; one rd_done pulse → third issued, outstanding back to 2.
- read_info_full=1, PU1 d_type 1, PU2 d_type 0 → PU2 granted, PU1 waits until full drops.
- rd_ready held 0 for 5 cycles in ISSUE → rd_req and fields stable, no grant; accept and rd_done same cycle → outstanding unchanged.
- rd_done with outstanding 0 → underflow_err 1, outstanding 0; reset asserted mid-ISSUE → all outputs 0 next cycle.
